// File: rtl/tic_pkg.sv
// Shared codes, state encoding and sizes for the tic-tac-toe turn controller.
package tic_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER   = 2'b01;
  localparam logic [1:0] COMPUTER = 2'b10;
  localparam logic [1:0] TIE      = 2'b11;

  localparam logic [3:0] CELL_MAX = 4'd8;
  localparam int         SCORE_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    P_WAIT,
    P_MOVE,
    C_WAIT,
    C_MOVE,
    CHECK,
    OVER
  } state_t;

endpackage

// File: rtl/game_ctrl_score_cnt.sv
// Saturating score counter; cleared only by the system reset so scores survive games.
module score_cnt
  import tic_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + SCORE_W'(1);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer and move arbiter for the 3x3 board, with score keeping.
// Optional player turn limit enabled by defining GAME_CTRL_TIMEOUT_EN.
module game_ctrl
  import tic_pkg::*;
#(
  parameter logic [1:0]  FIRST_MOVER    = 2'b01,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               player_valid,
  output logic               player_ready,
  input  logic [3:0]         player_addr,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic [3:0]         cpu_addr,
  output logic               player_move,
  output logic               computer_move,
  output logic [3:0]         player_address,
  output logic [3:0]         computer_address,
  output logic               board_rstn,
  input  logic               illegal_move,
  input  logic               win,
  input  logic               tie,
  input  logic [1:0]         winner,
  output logic [1:0]         turn,
  output logic               game_over,
  output logic [1:0]         result,
  output logic               bad_move,
  output logic [SCORE_W-1:0] score_p,
  output logic [SCORE_W-1:0] score_c,
  output logic [SCORE_W-1:0] score_t
);

  state_t     state;
  logic [1:0] check_cnt;
  logic       ill_cap;
  logic [1:0] mover;
  logic       decide;
  logic       timeout_hit;
  logic       inc_p, inc_c, inc_t;

  assign decide = (state == CHECK) && (check_cnt == 2'd1);

`ifdef GAME_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (state == P_WAIT) begin
      to_cnt <= to_cnt + 32'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // An accepted handshake in the expiry cycle takes precedence over the timeout.
  assign timeout_hit = (state == P_WAIT) && !player_valid &&
                       (to_cnt >= TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    inc_p = 1'b0;
    inc_c = 1'b0;
    inc_t = 1'b0;
    if (decide && !ill_cap) begin
      if (win) begin
        inc_p = (winner == PLAYER);
        inc_c = (winner == COMPUTER);
      end else if (tie) begin
        inc_t = 1'b1;
      end
    end
    if (timeout_hit) begin
      inc_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      player_ready     <= 1'b0;
      cpu_ready        <= 1'b0;
      player_move      <= 1'b0;
      computer_move    <= 1'b0;
      player_address   <= '0;
      computer_address <= '0;
      board_rstn       <= 1'b1;
      turn             <= EMPTY;
      game_over        <= 1'b0;
      result           <= EMPTY;
      bad_move         <= 1'b0;
      check_cnt        <= '0;
      ill_cap          <= 1'b0;
      mover            <= EMPTY;
    end else begin
      player_move   <= 1'b0;
      computer_move <= 1'b0;
      bad_move      <= 1'b0;
      board_rstn    <= 1'b1;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state      <= CLEAR;
            board_rstn <= 1'b0;
            game_over  <= 1'b0;
          end
        end
        CLEAR: begin
          result <= EMPTY;
          if (FIRST_MOVER == COMPUTER) begin
            state     <= C_WAIT;
            cpu_ready <= 1'b1;
            turn      <= COMPUTER;
          end else begin
            state        <= P_WAIT;
            player_ready <= 1'b1;
            turn         <= PLAYER;
          end
        end
        P_WAIT: begin
          if (player_valid) begin
            if (player_addr <= CELL_MAX) begin
              player_address <= player_addr;
              player_move    <= 1'b1;
              player_ready   <= 1'b0;
              state          <= P_MOVE;
            end else begin
              bad_move <= 1'b1;
            end
          end else if (timeout_hit) begin
            result       <= COMPUTER;
            player_ready <= 1'b0;
            turn         <= EMPTY;
            game_over    <= 1'b1;
            state        <= OVER;
          end
        end
        C_WAIT: begin
          if (cpu_valid) begin
            if (cpu_addr <= CELL_MAX) begin
              computer_address <= cpu_addr;
              computer_move    <= 1'b1;
              cpu_ready        <= 1'b0;
              state            <= C_MOVE;
            end else begin
              bad_move <= 1'b1;
            end
          end
        end
        P_MOVE: begin
          mover     <= PLAYER;
          check_cnt <= '0;
          state     <= CHECK;
        end
        C_MOVE: begin
          mover     <= COMPUTER;
          check_cnt <= '0;
          state     <= CHECK;
        end
        CHECK: begin
          if (check_cnt == 2'd0) begin
            ill_cap   <= illegal_move;
            check_cnt <= 2'd1;
          end else begin
            check_cnt <= '0;
            // Win is tested before tie: a winning ninth move raises both.
            if (ill_cap) begin
              bad_move <= 1'b1;
              if (mover == PLAYER) begin
                state        <= P_WAIT;
                player_ready <= 1'b1;
                turn         <= PLAYER;
              end else begin
                state     <= C_WAIT;
                cpu_ready <= 1'b1;
                turn      <= COMPUTER;
              end
            end else if (win || tie) begin
              result    <= win ? winner : TIE;
              turn      <= EMPTY;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (mover == PLAYER) begin
              state     <= C_WAIT;
              cpu_ready <= 1'b1;
              turn      <= COMPUTER;
            end else begin
              state        <= P_WAIT;
              player_ready <= 1'b1;
              turn         <= PLAYER;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  score_cnt u_score_p (.clk(clk), .rstn(rstn), .inc(inc_p), .count(score_p));
  score_cnt u_score_c (.clk(clk), .rstn(rstn), .inc(inc_c), .count(score_c));
  score_cnt u_score_t (.clk(clk), .rstn(rstn), .inc(inc_t), .count(score_t));

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Turn sequencer and requester arbiter for the 3x3 board. It accepts move requests from the player input path and the computer engine through valid/ready handshakes, and drives one-cycle move strobes and addresses into the board. It waits for the board's registered verdict, then alternates turns, retries on illegal moves and ends the game on win or tie. It also owns board clearing and keeps saturating score counters across games.

## Interface
- FIRST_MOVER, 2'b01: side that moves first in each game; 2'b01 = PLAYER, 2'b10 = COMPUTER.
- TIMEOUT_CYCLES, 32'd50_000_000: player turn limit in clock cycles; used only when GAME_CTRL_TIMEOUT_EN is defined.
- clk  in  1  system clock; one clock, all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  level; sampled in IDLE and OVER to begin a new game.
- player_valid / player_ready  in / out  1 / 1  player move handshake.
- player_addr  in  4  requested cell, 0..8.
- cpu_valid / cpu_ready  in / out  1 / 1  computer move handshake.
- cpu_addr  in  4  requested cell, 0..8.
- player_move / computer_move  out  1 / 1  one-cycle strobes to the board.
- player_address / computer_address  out  4 / 4  registered cell index to the board.
- board_rstn  out  1  registered active-low board clear.
- illegal_move, win, tie  in  1 each  registered status from the board.
- winner  in  2  board winner code.
- turn  out  2  side to move; 00 when no turn is active.
- game_over  out  1  high in OVER.
- result  out  2  01 player, 10 computer, 11 tie, 00 none.
- bad_move  out  1  one-cycle pulse when a move is rejected.
- score_p, score_c, score_t  out  4 each  saturating counts of player wins, computer wins and ties.

## Operation
- States: IDLE, CLEAR, P_WAIT, P_MOVE, C_WAIT, C_MOVE, CHECK, OVER.
- IDLE or OVER with start=1 → CLEAR. CLEAR drives board_rstn=0 for exactly one cycle, clears result, then goes to P_WAIT or C_WAIT according to FIRST_MOVER.
- P_WAIT: player_ready=1 and turn=01. On player_valid:
  - addr ≤ 8: latch player_address, go to P_MOVE.
  - addr > 8: pulse bad_move, stay in P_WAIT, issue no strobe.
- P_MOVE: player_move=1 for one cycle, then CHECK with the mover recorded.
- C_WAIT and C_MOVE mirror P_WAIT and P_MOVE, using cpu_ready, turn=10 and computer_move.
- CHECK lasts exactly 2 cycles, counted by a 2-bit counter. illegal_move is captured on the first CHECK cycle. Decision on the second CHECK cycle uses this priority:
  1. Captured illegal: pulse bad_move, return to the mover's WAIT state.
  2. win=1: result=winner, go to OVER.
  3. tie=1: result=11, go to OVER.
  4. Otherwise: go to the opponent's WAIT state.
- Win beats tie because the board may assert both together on a winning ninth move.
- OVER: game_over=1, both readies 0, turn=00. The matching score counter increments once on entry and saturates at 15.
- Only the current side's ready is ever high. The other side's valid is ignored with no side effect.
- start outside IDLE and OVER is ignored.
- Reset mid-game: all state returns to reset values immediately, scores included.

## Timing
- Reset values: state=IDLE, both readies 0, both strobes 0, both addresses 0, board_rstn=1, turn=00, game_over=0, result=00, bad_move=0, all scores 0.
- Handshake completes in the cycle where valid and ready are both 1.
- Latency from accepted request to turn change (next ready) is 4 cycles: P_MOVE, CHECK×2, then the WAIT state is entered.
- Strobe rises 1 cycle after acceptance.
- board_rstn low 1 cycle after start is sampled.

## Configuration
- GAME_CTRL_TIMEOUT_EN defined:
  - A counter runs while in P_WAIT and clears on leaving P_WAIT.
  - At TIMEOUT_CYCLES-1 with no handshake: result=10, score_c increments, go to OVER.
  - A handshake in the same cycle as expiry wins over the timeout.
- GAME_CTRL_TIMEOUT_EN undefined: no counter, and the player may wait indefinitely.

## Structure
- Shared package tic_pkg holds:
  - EMPTY/PLAYER/COMPUTER/TIE codes.
  - State encoding.
  - CELL_MAX=8.
  - SCORE_W=4.
- One sub-module, score_cnt: a saturating counter with increment and async clear, instantiated three times.

## Test plan
- Reset, start=1 → board_rstn low 1 cycle; then player_ready=1, turn=01.
- Player moves 0, 1, 2 interleaved with computer moves 3, 4 → result=01, game_over=1, score_p=1.
- Computer requests cell 4 when 4 is already occupied → bad_move pulse, back to C_WAIT, no turn change; next cpu_addr=5 is accepted.
- player_addr=4'd12 → bad_move 1 cycle later, player_move never asserted.
- Full board where the ninth move wins, so win=1 and tie=1 together → result equals the winner code, score_t unchanged.
- With GAME_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=10, leave the player idle → OVER after 10 cycles in P_WAIT, result=10; 16 repeated wins leave score_c=15.
